mul_approx_seq: RTL

//  Parametrised, iterative (one PP row per cycle) unsigned W x W multiplier with broken-array truncation.
//  Per-operation mode bit selects exact or approximate product.

---
 rtl/mul_approx_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_approx_seq.sv
// rtl/mul_approx_seq.sv - iterative W x W unsigned multiplier, exact or broken-array approximate per operation
// Optional APPROX_COMP_EN: adds a constant 2^(VBL-1) bias to approximate results, saturating.
module mul_approx_seq #(
   parameter int W   = 12,
   parameter int VBL = 12,
   parameter int HBL = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic           in_exact,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_prod,
   output logic           out_exact
);

   localparam int PW = 2 * W;
   localparam int RW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [RW-1:0] ROW_LAST    = RW'(W - 1);
   localparam logic [RW-1:0] ROW_APPROX0 = RW'(HBL);

`ifdef APPROX_COMP_EN
   localparam int            BIAS_SH = (VBL > 0) ? (VBL - 1) : 0;
   localparam logic [PW-1:0] BIAS    = (VBL > 0) ? (PW'(1) << BIAS_SH) : '0;
`endif

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          exact_q, exact_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [RW-1:0] row_q, row_d;

   logic [W-1:0]  mask;
   logic [PW-1:0] addend;
   logic [PW-1:0] acc_run;
   logic          last_row;

   // Broken-array mask: in approx mode a bit survives only if its column reaches VBL.
   always_comb begin
      mask = '0;
      for (int j = 0; j < W; j++) begin
         mask[j] = exact_q || ((int'(row_q) + j) >= VBL);
      end
   end

   always_comb begin
      addend = '0;
      if (b_q[row_q]) begin
         addend = PW'(a_q & mask) << row_q;
      end
   end

   assign last_row = (row_q == ROW_LAST);

`ifdef APPROX_COMP_EN
   logic [PW:0] biased;

   // Partial sums never overflow; only the bias can push past full scale.
   always_comb begin
      biased  = {1'b0, acc_q + addend};
      if (last_row && !exact_q) begin
         biased = biased + {1'b0, BIAS};
      end
      acc_run = biased[PW] ? '1 : biased[PW-1:0];
   end
`else
   always_comb begin
      acc_run = acc_q + addend;
   end
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      exact_d = exact_q;
      acc_d   = acc_q;
      row_d   = row_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
               a_d     = in_a;
               b_d     = in_b;
               exact_d = in_exact;
               acc_d   = '0;
               row_d   = in_exact ? '0 : ROW_APPROX0;
            end
         end
         ST_RUN: begin
            acc_d = acc_run;
            if (last_row) begin
               state_d = ST_DONE;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         exact_q <= 1'b0;
         acc_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         exact_q <= exact_d;
         acc_q   <= acc_d;
         row_q   <= row_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_prod  = acc_q;
   assign out_exact = exact_q;

endmodule
